// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: buffers raw RV32 instruction words in a small circular
// FIFO and presents one registered, decoded instruction per cycle to ESM.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends only on FIFO occupancy and rst, never on
// out_ready. out_valid, once high, holds Instr/ALUSrc/RegWrite bit-stable
// until a cycle with out_ready high.
module fetch_decode_stage #(
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [31:0]              in_instr,
  output logic                     in_ready,
  input  logic                     flush,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [31:0]              Instr,
  output logic                     ALUSrc,
  output logic                     RegWrite,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              illegal_cnt
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   head;
  logic          push;
  logic          pop;
  logic [31:0]   dec_instr;
  logic          dec_alu;
  logic          dec_rw;
  logic          dec_ill;

  // A full FIFO refuses words even if the head is popped in the same cycle.
  assign in_ready = (count != FULL) && !rst;
  assign push     = in_valid && in_ready && !flush;
  assign pop      = (!out_valid || out_ready) && (count != '0) && !flush;
  assign head     = mem[rd_ptr];

  // Storage array: written on accepted words only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_instr;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // Opcode decode of the FIFO head; unsupported opcodes become NOP.
  always_comb begin
    dec_instr = head;
    dec_alu   = 1'b0;
    dec_rw    = 1'b0;
    dec_ill   = 1'b0;
    case (head[6:0])
      7'b0010011, 7'b0000011: begin dec_alu = 1'b1; dec_rw = 1'b1; end
      7'b0110011, 7'b1010011: begin dec_rw = 1'b1; end
      7'b0100011:             begin dec_alu = 1'b1; end
      7'b1100011:             begin end
      default: begin
        dec_instr = NOP;
        dec_alu   = 1'b1;
        dec_ill   = 1'b1;
      end
    endcase
    // Writes to x0 are architecturally discarded.
    if (head[11:7] == 5'd0) dec_rw = 1'b0;
  end

  // Output register: load on pop, drop valid once consumed with nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      Instr     <= NOP;
      ALUSrc    <= 1'b0;
      RegWrite  <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      Instr     <= NOP;
      ALUSrc    <= 1'b0;
      RegWrite  <= 1'b0;
    end else if (pop) begin
      out_valid <= 1'b1;
      Instr     <= dec_instr;
      ALUSrc    <= dec_alu;
      RegWrite  <= dec_rw;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Saturating count of substituted words; survives flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_cnt <= '0;
    end else if (pop && dec_ill && (illegal_cnt != 16'hFFFF)) begin
      illegal_cnt <= illegal_cnt + 16'd1;
    end
  end

endmodule

// File: doc/fetch_decode_stage.md
# fetch_decode_stage

Upstream neighbour of the ESM block: accepts raw 32-bit RV32 instruction words from the instruction source over a valid/ready handshake, buffers them in a small FIFO, and presents one registered instruction per cycle to ESM together with the `ALUSrc` and `RegWrite` controls derived from its opcode. Absorbs downstream stalls without dropping words. Replaces unsupported opcodes with a NOP and counts them.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `NOP`, 32'h00000013, substitute word for illegal opcodes (addi x0,x0,0).

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  `in_instr` holds a word.
- `in_instr`  in  32  instruction word from the source.
- `in_ready`  out  1  stage can accept a word this cycle.
- `flush`  in  1  synchronous discard of all buffered and presented words.
- `out_ready`  in  1  ESM consumes the presented word this cycle.
- `out_valid`  out  1  `Instr`/`ALUSrc`/`RegWrite` are valid.
- `Instr`  out  32  instruction to ESM `Instr_in`.
- `ALUSrc`  out  1  1 = second ALU operand is the immediate.
- `RegWrite`  out  1  1 = instruction writes rd.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy (excludes the output register).
- `illegal_cnt`  out  16  saturating count of substituted words.

## Operation
- FIFO: circular buffer, write/read pointers wrap modulo DEPTH; `count` 0..DEPTH.
- Enqueue when `in_valid && in_ready`. `in_ready = (count != DEPTH) && !rst`; it does not depend on `out_ready` (no enqueue into a full FIFO even if a dequeue occurs that cycle).
- Output register load condition: `(!out_valid || out_ready) && count != 0`. On load, pop the FIFO head, decode, register results, set `out_valid=1`.
- If the load condition is false because `count == 0` and `out_ready` consumed the current word, `out_valid` drops to 0; `Instr`/controls hold their last values.
- Decode by opcode `[6:0]`:
  - 0010011 OP-IMM, 0000011 LOAD: ALUSrc=1, RegWrite=1.
  - 0110011 OP, 1010011 OP-FP: ALUSrc=0, RegWrite=1.
  - 0100011 STORE: ALUSrc=1, RegWrite=0.
  - 1100011 BRANCH: ALUSrc=0, RegWrite=0.
  - any other: `Instr=NOP`, ALUSrc=1, RegWrite=0; `illegal_cnt` +1, saturating at 16'hFFFF.
- For legal RegWrite opcodes, rd (`[11:7]`) == 0 forces RegWrite=0. Legal words pass through to `Instr` unchanged.
- `flush` (priority over all else): pointers and `count` to 0, `out_valid=0`, `Instr=NOP`, ALUSrc=0, RegWrite=0; an enqueue offered in the same cycle is dropped. `illegal_cnt` is not cleared.

## Timing
- Reset values: `out_valid=0`, `Instr=NOP`, `ALUSrc=0`, `RegWrite=0`, `count=0`, `illegal_cnt=0`, `in_ready=0` while `rst` high, 1 in the first cycle after release.
- Latency: a word accepted at edge k, with FIFO previously empty and output free, appears on outputs after edge k+1. No combinational bypass from `in_instr` to outputs.
- Throughput: one word per cycle sustained with `in_valid=out_ready=1`; `count` stays at 0 or 1.
- Stall: while `out_valid && !out_ready`, outputs are held bit-stable; the FIFO keeps filling until `count==DEPTH`, then `in_ready=0`.
- Simultaneous enqueue and pop with `count<DEPTH`: `count` unchanged.
- Reset mid-operation: immediately returns to reset values; buffered words are lost.
- `flush` takes effect at the edge it is sampled; next cycle `out_valid=0`, `count=0`.

## Test plan
- Reset then stream 0x00100093, 0x00000113, 0x003101B3 with `out_ready=1` -> outputs after edges k+1..k+3: (0x00100093,A=1,W=1), (0x00000113,A=1,W=1), (0x003101B3,A=0,W=1); `count≤1`.
- Hold `out_ready=0`, offer 6 words at DEPTH=4 -> 1 in the output register, `count=4`, `in_ready=0`, words 6+ not accepted; release -> all 5 delivered in order, none duplicated.
- Words 0x00000063 (BRANCH, rd=0), 0x00102023 (STORE), 0x00000033 (OP, rd=0) -> controls (A=0,W=0), (A=1,W=0), (A=0,W=0).
- Illegal 0xFFFFFFFF and 0x0000007F -> `Instr=0x00000013`, A=1, W=0 each; `illegal_cnt=2`.
- With `count=3` and `out_valid=1`, assert `flush` together with `in_valid` -> next cycle `count=0`, `out_valid=0`, `Instr=NOP`; offered word not delivered.
- Assert `rst` asynchronously mid-stream between edges -> outputs reach reset values before the next edge; `illegal_cnt=0`.
